// File: rtl/hash_pair_scheduler_if.sv
// -----------------------------------------------------------------------------
// hash_pair_scheduler_if
// Request and response channels of the hash pair scheduler.
//   req_valid  [1:0]   request valid, one bit per requester
//   req_vpn0/1 VPN_W   VPN offered by requester 0 / 1
//   req_ready  [1:0]   request accepted (one-hot or zero)
//   resp_valid         result pair valid
//   resp_ready         consumer accepts the result pair
//   resp_src           requester owning the response
//   resp_hash0/1       hash function 0 / 1 results
// master: requesters + response consumer side. slave: the scheduler.
// -----------------------------------------------------------------------------
interface hash_pair_scheduler_if #(
   parameter int VPN_W  = 45,
   parameter int HASH_W = 32
);
   logic [1:0]        req_valid;
   logic [VPN_W-1:0]  req_vpn0;
   logic [VPN_W-1:0]  req_vpn1;
   logic [1:0]        req_ready;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_src;
   logic [HASH_W-1:0] resp_hash0;
   logic [HASH_W-1:0] resp_hash1;

   modport master (
      output req_valid, req_vpn0, req_vpn1, resp_ready,
      input  req_ready, resp_valid, resp_src, resp_hash0, resp_hash1
   );

   modport slave (
      input  req_valid, req_vpn0, req_vpn1, resp_ready,
      output req_ready, resp_valid, resp_src, resp_hash0, resp_hash1
   );
endinterface

// File: rtl/hash_pair_scheduler.sv
// -----------------------------------------------------------------------------
// hash_pair_scheduler
// Round-robin arbiter and sequencer for the shared two-function tabulation
// hash unit. A granted VPN is hashed with function 0 then function 1; both
// results are returned with the owning requester ID.
//   clk       single clock
//   rst_n     asynchronous active-low reset
//   bus       request/response channels (slave side)
//   hash_vpn  VPN driven to the hash unit (always the latched VPN)
//   hash_id   hash function select (1 only in the second issue cycle)
//   hash_out  hash unit result, registered, valid one cycle after issue
//   busy      high whenever a request is in flight or a response is pending
// -----------------------------------------------------------------------------
module hash_pair_scheduler #(
   parameter int VPN_W  = 45,
   parameter int HASH_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hash_pair_scheduler_if.slave bus,
   output logic [VPN_W-1:0]     hash_vpn,
   output logic                 hash_id,
   input  logic [HASH_W-1:0]    hash_out,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE0 = 3'd1,
      ISSUE1 = 3'd2,
      WAIT1  = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic              grant_s;
   logic              hs_s;
   logic [1:0]        req_ready_s;
   logic [VPN_W-1:0]  vpn_r;
   logic              src_r;
   logic              ptr_r;        // 1: prefer requester 1 on contention
   logic [HASH_W-1:0] hash0_r;
   logic [HASH_W-1:0] hash1_r;
   logic              hash_id_r;
   logic              busy_r;
   logic              resp_valid_r;

   // Next-state, grant selection and request handshake decode
   always_comb begin
      state_nx_s  = state_r;
      grant_s     = 1'b0;
      hs_s        = 1'b0;
      req_ready_s = 2'b00;
      case (state_r)
         IDLE: begin
            if (bus.req_valid == 2'b11) begin
               grant_s = ptr_r;
            end else begin
               grant_s = bus.req_valid[1];
            end
            if (bus.req_valid != 2'b00) begin
               hs_s        = 1'b1;
               req_ready_s = grant_s ? 2'b10 : 2'b01;
               state_nx_s  = ISSUE0;
            end else begin
               state_nx_s  = IDLE;
            end
         end
         ISSUE0:  state_nx_s = ISSUE1;
         ISSUE1:  state_nx_s = WAIT1;
         WAIT1:   state_nx_s = RESP;
         RESP: begin
            if (bus.resp_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = RESP;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Request latch, priority pointer, result capture and registered flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpn_r        <= {VPN_W{1'b0}};
         src_r        <= 1'b0;
         ptr_r        <= 1'b0;
         hash0_r      <= {HASH_W{1'b0}};
         hash1_r      <= {HASH_W{1'b0}};
         hash_id_r    <= 1'b0;
         busy_r       <= 1'b0;
         resp_valid_r <= 1'b0;
      end else begin
         if (hs_s) begin
            vpn_r <= grant_s ? bus.req_vpn1 : bus.req_vpn0;
            src_r <= grant_s;
            ptr_r <= ~grant_s;
         end
         // hash_out lags the issue by one cycle: function 0 result is
         // present during ISSUE1, function 1 result during WAIT1.
         if (state_r == ISSUE1) begin
            hash0_r <= hash_out;
         end
         if (state_r == WAIT1) begin
            hash1_r <= hash_out;
         end
         // Flags are precomputed from the next state so they are flops
         // yet line up exactly with the state they describe.
         hash_id_r    <= (state_nx_s == ISSUE1);
         busy_r       <= (state_nx_s != IDLE);
         resp_valid_r <= (state_nx_s == RESP);
      end
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_src   = src_r;
   assign bus.resp_hash0 = hash0_r;
   assign bus.resp_hash1 = hash1_r;
   assign hash_vpn       = vpn_r;
   assign hash_id        = hash_id_r;
   assign busy           = busy_r;

endmodule

// File: doc/hash_pair_scheduler.md
# hash_pair_scheduler

Sequencer and arbiter for the shared two-function tabulation hash unit used by the cuckoo page-table lookup path. It accepts virtual-page-number lookup requests from two requesters and grants them round-robin. For each granted request it drives the hash unit first with hash function 0, then with hash function 1, and collects both 32-bit results. It returns the result pair with the winning requester's ID over a valid/ready response channel.

## Interface
Parameters:
- VPN_W, 45, virtual page number width; matches the hash unit input.
- HASH_W, 32, hash result width; matches the hash unit output.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  2  request valid, one bit per requester (bit 0 = requester 0).
- req_vpn0  in  VPN_W  VPN from requester 0; sampled only on its handshake.
- req_vpn1  in  VPN_W  VPN from requester 1; sampled only on its handshake.
- req_ready  out  2  request accepted; at most one bit high per cycle.
- hash_vpn  out  VPN_W  VPN driven to the hash unit.
- hash_id  out  1  hash function select driven to the hash unit.
- hash_out  in  HASH_W  hash unit result; registered, valid 1 cycle after hash_vpn/hash_id.
- resp_valid  out  1  result pair valid.
- resp_ready  in  1  consumer accepts the result pair.
- resp_src  out  1  requester that owns the response.
- resp_hash0  out  HASH_W  hash function 0 result.
- resp_hash1  out  HASH_W  hash function 1 result.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT1, RESP.
- IDLE: the grant goes to the requester with req_valid high. If both are high, the grant goes to the requester indicated by the priority pointer.
  - req_ready[g] is asserted combinationally for the granted requester only, in IDLE only.
  - On the handshake, the VPN is latched into vpn_q and g into src_q; the pointer is set to prefer ~g. Next state is ISSUE0.
- ISSUE0: hash_vpn=vpn_q, hash_id=0. Next state is ISSUE1.
- ISSUE1: hash_vpn=vpn_q, hash_id=1. hash_out carries the function-0 result and is captured into resp_hash0. Next state is WAIT1.
- WAIT1: hash_id=0. hash_out carries the function-1 result and is captured into resp_hash1. Next state is RESP.
- RESP: resp_valid=1. resp_src, resp_hash0 and resp_hash1 are held stable until resp_ready. On resp_valid&&resp_ready the next state is IDLE; otherwise RESP holds.
- hash_vpn always reflects vpn_q. hash_id is 1 only in ISSUE1.
- Priority pointer resets to prefer requester 0. It changes only on a grant.
- A requester that drops req_valid without a handshake loses nothing. No request is ever partially accepted.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_src=0, resp_hash0=0, resp_hash1=0, hash_vpn=0, hash_id=0, busy=0. State is IDLE and the pointer prefers requester 0.
- Reset asserted mid-operation clears the FSM immediately to IDLE. Any in-flight request and any pending response are discarded; no response is produced after release.
- Latency: handshake in cycle T gives resp_valid high in cycle T+4.
- Throughput: with resp_ready tied high, one request is accepted per 5 cycles (IDLE, ISSUE0, ISSUE1, WAIT1, RESP).
- No request is accepted while busy. req_ready is 0 in every non-IDLE state, including RESP.
- Backpressure: resp_valid stays high and outputs stay constant for any number of cycles with resp_ready low.
- resp_ready high outside RESP has no effect.
- If req_valid and resp_ready are high together in RESP, the request is not accepted that cycle. It may be accepted in the following IDLE cycle.

## Test plan
The bench hash model registers hash_out <= hash_vpn[31:0] ^ (hash_id ? 32'hFFFF_FFFF : 0).
- Single request from requester 0 with vpn=45'h1234_5678 at cycle T, resp_ready=1 -> resp_valid at T+4, resp_src=0, resp_hash0=32'h1234_5678, resp_hash1=32'hEDCB_A987; busy falls at T+5.
- Both req_valid held high continuously, vpn0=45'h1, vpn1=45'h2 -> grants alternate 0,1,0,1 starting with 0, one every 5 cycles. Responses carry hash0=1/2 with matching resp_src.
- Backpressure: resp_ready low for 7 cycles in RESP -> resp_valid and hash outputs stable for all 7 cycles and req_ready=0. Accept occurs in the cycle resp_ready rises; IDLE follows.
- Requester 1 alone with vpn=45'h1F_FFFF_FFFF_FF -> resp_src=1, resp_hash0=32'hFFFF_FFFF, resp_hash1=32'h0000_0000. The next concurrent contention grants requester 0.
- rst_n pulled low during ISSUE1 -> all outputs return to reset values asynchronously. After release no resp_valid appears, and a new request completes normally with latency 4.
- Requester 0 raises req_valid while the block is in WAIT1 -> req_ready stays 0 until IDLE, then the handshake completes and vpn0 is sampled at that handshake cycle.
